// File: rtl/fp_accum.sv
// Binary32 accumulator: sums TERMS products through an align/add/normalize sequence
// and presents the total on a valid/ready output, then clears for the next frame.
module fp_accum #(
    parameter int TERMS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int CW = $clog2(TERMS + 1);
    localparam logic [CW-1:0] LAST_TERM = CW'(TERMS);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [31:0]   acc;
    logic [31:0]   op;

    logic          big_sign;
    logic [7:0]    big_exp;
    logic [23:0]   big_man;
    logic [23:0]   small_man;
    logic          sub;
    logic [24:0]   raw_sum;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Operand ordering and alignment; an exponent field of 0 means the value is zero.
    logic [7:0]  op_exp, acc_exp, b_exp, s_exp, exp_diff;
    logic [23:0] op_man, acc_man, b_man, s_man, s_aligned;
    logic        b_sign;

    always_comb begin
        op_exp  = op[30:23];
        acc_exp = acc[30:23];
        op_man  = (op_exp == 8'd0) ? 24'd0 : {1'b1, op[22:0]};
        acc_man = (acc_exp == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
        if ({op_exp, op_man} >= {acc_exp, acc_man}) begin
            b_sign = op[31];
            b_exp  = op_exp;
            b_man  = op_man;
            s_exp  = acc_exp;
            s_man  = acc_man;
        end else begin
            b_sign = acc[31];
            b_exp  = acc_exp;
            b_man  = acc_man;
            s_exp  = op_exp;
            s_man  = op_man;
        end
        exp_diff  = b_exp - s_exp;
        s_aligned = (exp_diff >= 8'd24) ? 24'd0 : (s_man >> exp_diff);
    end

    // Normalization of the raw sum into a binary32 result with flush and saturation.
    logic [4:0]  lz;
    logic [23:0] norm_man;
    logic [9:0]  norm_exp;
    logic [31:0] norm_result;

    always_comb begin
        lz = lzc24(raw_sum[23:0]);
        if (raw_sum[24]) begin
            norm_man = raw_sum[24:1];
            norm_exp = {2'b00, big_exp} + 10'd1;
        end else begin
            norm_man = raw_sum[23:0] << lz;
            norm_exp = {2'b00, big_exp} - {5'd0, lz};
        end
        if (raw_sum == 25'd0 || norm_exp[9] || norm_exp == 10'd0) begin
            norm_result = 32'd0;
        end else if (norm_exp >= 10'd255) begin
            norm_result = {big_sign, 8'hFE, 23'h7FFFFF};
        end else begin
            norm_result = {big_sign, norm_exp[7:0], norm_man[22:0]};
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ALIGN;
            end
            ALIGN: state_next = ADD;
            ADD:   state_next = NORM;
            NORM:  state_next = (cnt == LAST_TERM) ? OUT : IDLE;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= 32'd0;
            cnt      <= '0;
            out_data <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) cnt <= cnt + 1'b1;
                NORM: begin
                    acc <= norm_result;
                    if (cnt == LAST_TERM) out_data <= norm_result;
                end
                OUT: if (out_ready) begin
                    acc <= 32'd0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: pipeline operand registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (in_valid) op <= in_data;
            ALIGN: begin
                big_sign  <= b_sign;
                big_exp   <= b_exp;
                big_man   <= b_man;
                small_man <= s_aligned;
                sub       <= op[31] ^ acc[31];
            end
            ADD: raw_sum <= sub ? ({1'b0, big_man} - {1'b0, small_man})
                                : ({1'b0, big_man} + {1'b0, small_man});
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_accum.sv
// Self-checking bench for fp_accum: real-valued frame model with per-cycle output
// comparison, plus directed frames with hand-computed binary32 results.
module tb_fp_accum;

    localparam int TERMS = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int prev_cyc = 0;

    fp_accum #(.TERMS(TERMS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic real to_real(input logic [31:0] b);
        real m;
        if (b[30:23] == 8'd0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
        return b[31] ? -m : m;
    endfunction

    // Truncating conversion to binary32, matching the block's no-rounding arithmetic.
    function automatic logic [31:0] to_bits(input real r);
        real a;
        int  e;
        logic [31:0] f;
        if (r == 0.0) return 32'd0;
        a = (r < 0.0) ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e <= 0) return 32'd0;
        if (e >= 255) return {r < 0.0, 8'hFE, 23'h7FFFFF};
        f = 32'($rtoi((a - 1.0) * 8388608.0));
        return {r < 0.0, 8'(e), f[22:0]};
    endfunction

    // Model state: accepted terms, busy countdown, pending output, last presented value.
    real         m_sum   = 0.0;
    int          m_terms = 0;
    int          m_busy  = 0;
    bit          m_pend  = 0;
    logic [31:0] m_last  = 32'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready",  {31'd0, in_ready},  {31'd0, (m_busy == 0) && !m_pend});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_pend});
            check("out_data",  out_data, m_last);
        end
        if (!rst_n) begin
            m_sum = 0.0; m_terms = 0; m_busy = 0; m_pend = 0; m_last = 32'd0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_terms == TERMS) begin
                m_pend = 1;
                m_last = to_bits(m_sum);
                m_sum = 0.0;
                m_terms = 0;
            end
        end else if (m_pend) begin
            if (out_ready) m_pend = 0;
        end else if (in_valid) begin
            m_sum += to_real(in_data);
            m_terms++;
            m_busy = 3;
        end
    end

    task automatic send(input logic [31:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        prev_cyc = acc_cyc;
        acc_cyc  = cyc;
    endtask

    task automatic wait_out(output logic [31:0] r);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (out_valid) check("out_latency", 32'(cyc - acc_cyc), 32'd3);
        else check("out_timeout", {31'd0, out_valid}, 32'd1);
        r = out_data;
    endtask

    task automatic run_frame(input logic [31:0] v [TERMS], output logic [31:0] r);
        for (int i = 0; i < TERMS; i++) begin
            send(v[i]);
            if (i > 0) check("accept_gap", 32'(acc_cyc - prev_cyc), 32'd4);
        end
        wait_out(r);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] ones [TERMS];
    logic [31:0] vec  [TERMS];
    logic [31:0] res;
    logic [31:0] held;

    initial begin
        for (int i = 0; i < TERMS; i++) ones[i] = 32'h3F800000;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;

        // Model pins
        check("pin_mixed", to_bits(to_real(32'h3FC00000) + to_real(32'hBE800000)), 32'h3FA00000);
        check("pin_align", to_bits(to_real(32'h3F800000) + to_real(32'h30800000)), 32'h3F800000);

        // Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h00000000);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset with in_valid high: nothing accepted
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h3F800000; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic sum
        run_frame(ones, res);
        check("basic_9", res, 32'h41100000);

        // Mixed signs
        vec = '{default: 32'h00000000};
        vec[0] = 32'h3FC00000; vec[1] = 32'hBE800000;
        run_frame(vec, res);
        check("mixed_1p25", res, 32'h3FA00000);

        // Exact cancellation
        vec = '{default: 32'h00000000};
        vec[0] = 32'h40200000; vec[1] = 32'hC0200000;
        run_frame(vec, res);
        check("cancel_zero", res, 32'h00000000);

        // Alignment loss
        vec = '{default: 32'h00000000};
        vec[0] = 32'h3F800000; vec[1] = 32'h30800000;
        run_frame(vec, res);
        check("align_loss", res, 32'h3F800000);

        // Backpressure
        out_ready = 1'b0;
        run_frame(ones, res);
        held = res;
        check("bp_first", res, 32'h41100000);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, held);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", {31'd0, out_valid}, 32'd0);
        check("bp_data_kept", out_data, held);
        run_frame(ones, res);
        check("bp_second", res, 32'h41100000);

        // Mid-frame reset
        for (int i = 0; i < 4; i++) send(32'h3F800000);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_frame(ones, res);
        check("midrst_9", res, 32'h41100000);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
